// File: rtl/sq_trigseq.sv
// Trigger sequencer: arm, wait for sq_trigger, hold off, open a capture window.
// Configured and polled over an 8-bit Wishbone register bus.
module sq_trigseq #(
   parameter int CNT_W = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   output logic       sq_active,
   input  logic       sq_trigger,
   output logic       capture_en,
   output logic       done_pulse,
   input  logic       wb_stb_i,
   input  logic       wb_cyc_i,
   input  logic       wb_we_i,
   input  logic [15:0] wb_adr_i,
   input  logic [7:0] wb_dat_i,
   output logic [7:0] wb_dat_o,
   output logic       wb_ack_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARMED,
      S_DELAY,
      S_CAPTURE,
      S_DONE
   } state_t;

   state_t state_q, state_d;

   logic [CNT_W-1:0] delay_q, delay_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic done_q, done_d;
   logic sq_active_q, sq_active_d;
   logic capture_en_q, capture_en_d;
   logic done_pulse_q, done_pulse_d;
   logic in_done_q, in_done_d;

   logic       wr_en;
   logic       wr_ctl;
   logic       arm;
   logic       abort;
   logic       cfg_ok;
   logic [2:0] adr;
   logic [15:0] delay_x;
   logic [15:0] count_x;
   logic       unused_adr;

   assign adr        = wb_adr_i[2:0];
   assign unused_adr = ^wb_adr_i[15:3];
   assign wr_en      = wb_cyc_i & wb_stb_i & wb_we_i;
   assign wr_ctl     = wr_en & (adr == 3'd0);
   assign abort      = wr_ctl & wb_dat_i[1];
   assign arm        = wr_ctl & wb_dat_i[0] & ~wb_dat_i[1];
   assign cfg_ok     = (state_q == S_IDLE) | (state_q == S_DONE);
   assign delay_x    = 16'(delay_q);
   assign count_x    = 16'(count_q);

   always_comb begin : cfg_regs
      delay_d = delay_q;
      count_d = count_q;
      if (wr_en && cfg_ok) begin
         case (adr)
            3'd1: delay_d = CNT_W'({delay_x[15:8], wb_dat_i});
            3'd2: delay_d = CNT_W'({wb_dat_i, delay_x[7:0]});
            3'd3: count_d = CNT_W'({count_x[15:8], wb_dat_i});
            3'd4: count_d = CNT_W'({wb_dat_i, count_x[7:0]});
            default: ;
         endcase
      end
   end

   always_comb begin : fsm
      state_d = state_q;
      cnt_d   = cnt_q;
      done_d  = done_q;
      if (abort) begin
         state_d = S_IDLE;
      end else begin
         unique case (state_q)
            S_IDLE, S_DONE: begin
               if (arm) begin
                  state_d = S_ARMED;
                  done_d  = 1'b0;
               end
            end
            S_ARMED: begin
               if (sq_trigger) begin
                  if (delay_q != '0) begin
                     state_d = S_DELAY;
                     cnt_d   = delay_q;
                  end else if (count_q != '0) begin
                     state_d = S_CAPTURE;
                     cnt_d   = count_q;
                  end else begin
                     state_d = S_DONE;
                  end
               end
            end
            S_DELAY: begin
               if (cnt_q == CNT_W'(1)) begin
                  if (count_q != '0) begin
                     state_d = S_CAPTURE;
                     cnt_d   = count_q;
                  end else begin
                     state_d = S_DONE;
                  end
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
            S_CAPTURE: begin
               if (cnt_q == CNT_W'(1)) begin
                  state_d = S_DONE;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
      if (state_d == S_DONE && state_q != S_DONE) begin
         done_d = 1'b1;
      end
   end

   // Outputs are registered decodes; abort suppresses them on its own edge.
   always_comb begin : outs
      sq_active_d  = (state_d == S_ARMED);
      capture_en_d = (state_q == S_CAPTURE) & ~abort;
      in_done_d    = (state_q == S_DONE);
      done_pulse_d = (state_q == S_DONE) & ~in_done_q & ~abort;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         delay_q      <= '0;
         count_q      <= '0;
         cnt_q        <= '0;
         done_q       <= 1'b0;
         sq_active_q  <= 1'b0;
         capture_en_q <= 1'b0;
         done_pulse_q <= 1'b0;
         in_done_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         delay_q      <= delay_d;
         count_q      <= count_d;
         cnt_q        <= cnt_d;
         done_q       <= done_d;
         sq_active_q  <= sq_active_d;
         capture_en_q <= capture_en_d;
         done_pulse_q <= done_pulse_d;
         in_done_q    <= in_done_d;
      end
   end

   always_comb begin : rd_mux
      wb_dat_o = 8'h00;
      case (adr)
         3'd0: wb_dat_o = {5'b0, done_q,
                           (state_q == S_DELAY) | (state_q == S_CAPTURE),
                           (state_q == S_ARMED)};
         3'd1: wb_dat_o = delay_x[7:0];
         3'd2: wb_dat_o = delay_x[15:8];
         3'd3: wb_dat_o = count_x[7:0];
         3'd4: wb_dat_o = count_x[15:8];
         default: wb_dat_o = 8'h00;
      endcase
   end

   assign sq_active  = sq_active_q;
   assign capture_en = capture_en_q;
   assign done_pulse = done_pulse_q;
   assign wb_ack_o   = 1'b1;

endmodule

// File: tb/tb_sq_trigseq.sv
// Directed bench for sq_trigseq: arm/trigger/delay/capture/abort/reset.
// Inputs change 1ns after a rising edge; outputs are checked in that window.
module tb_sq_trigseq;

   logic       clk;
   logic       rst_n;
   logic       sq_active;
   logic       sq_trigger;
   logic       capture_en;
   logic       done_pulse;
   logic       wb_stb_i;
   logic       wb_cyc_i;
   logic       wb_we_i;
   logic [15:0] wb_adr_i;
   logic [7:0] wb_dat_i;
   logic [7:0] wb_dat_o;
   logic       wb_ack_o;

   int n_cmp;
   int n_err;
   int n_cap;
   int n_dp;
   int first_cap;
   logic [7:0] rd_v;

   sq_trigseq #(.CNT_W(16)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .sq_active  (sq_active),
      .sq_trigger (sq_trigger),
      .capture_en (capture_en),
      .done_pulse (done_pulse),
      .wb_stb_i   (wb_stb_i),
      .wb_cyc_i   (wb_cyc_i),
      .wb_we_i    (wb_we_i),
      .wb_adr_i   (wb_adr_i),
      .wb_dat_i   (wb_dat_i),
      .wb_dat_o   (wb_dat_o),
      .wb_ack_o   (wb_ack_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got,
                        input logic [15:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [2:0] a, input logic [7:0] d);
      wb_adr_i = {13'h0, a};
      wb_dat_i = d;
      wb_cyc_i = 1'b1;
      wb_stb_i = 1'b1;
      wb_we_i  = 1'b1;
      tick();
      wb_cyc_i = 1'b0;
      wb_stb_i = 1'b0;
      wb_we_i  = 1'b0;
   endtask

   task automatic rd(input logic [2:0] a, output logic [7:0] d);
      wb_adr_i = {13'h0, a};
      wb_cyc_i = 1'b1;
      wb_stb_i = 1'b1;
      wb_we_i  = 1'b0;
      #1;
      d = wb_dat_o;
      wb_cyc_i = 1'b0;
      wb_stb_i = 1'b0;
   endtask

   task automatic trig();
      sq_trigger = 1'b1;
      tick();
      sq_trigger = 1'b0;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst_n = 1'b0;
      sq_trigger = 1'b0;
      wb_stb_i = 1'b0;
      wb_cyc_i = 1'b0;
      wb_we_i = 1'b0;
      wb_adr_i = '0;
      wb_dat_i = '0;
      tick();
      tick();
      check("rst_active", {15'h0, sq_active}, 16'h0);
      check("rst_cap", {15'h0, capture_en}, 16'h0);
      check("rst_dp", {15'h0, done_pulse}, 16'h0);
      check("ack", {15'h0, wb_ack_o}, 16'h1);
      rd(3'd0, rd_v);
      check("rst_stat", {8'h0, rd_v}, 16'h00);
      rst_n = 1'b1;
      tick();

      // 1: delay 0, count 4
      wr(3'd1, 8'h00);
      wr(3'd2, 8'h00);
      wr(3'd3, 8'h04);
      wr(3'd4, 8'h00);
      wr(3'd0, 8'h01);
      check("t1_active_pre", {15'h0, sq_active}, 16'h1);
      rd(3'd0, rd_v);
      check("t1_stat_armed", {8'h0, rd_v}, 16'h01);
      trig();
      check("t1_active_post", {15'h0, sq_active}, 16'h0);
      check("t1_cap_T", {15'h0, capture_en}, 16'h0);
      for (int i = 1; i <= 4; i++) begin
         tick();
         check("t1_cap_on", {15'h0, capture_en}, 16'h1);
         check("t1_dp_low", {15'h0, done_pulse}, 16'h0);
      end
      tick();
      check("t1_cap_off", {15'h0, capture_en}, 16'h0);
      check("t1_dp", {15'h0, done_pulse}, 16'h1);
      tick();
      check("t1_dp_once", {15'h0, done_pulse}, 16'h0);
      rd(3'd0, rd_v);
      check("t1_stat_done", {8'h0, rd_v}, 16'h04);

      // 2: delay 3, count 2, extra trigger in DELAY
      wr(3'd1, 8'h03);
      wr(3'd3, 8'h02);
      wr(3'd0, 8'h01);
      rd(3'd0, rd_v);
      check("t2_stat_armed", {8'h0, rd_v}, 16'h01);
      trig();
      rd(3'd0, rd_v);
      check("t2_stat_busy", {8'h0, rd_v}, 16'h02);
      trig();
      check("t2_cap_T1", {15'h0, capture_en}, 16'h0);
      tick();
      check("t2_cap_T2", {15'h0, capture_en}, 16'h0);
      tick();
      check("t2_cap_T3", {15'h0, capture_en}, 16'h0);
      tick();
      check("t2_cap_T4", {15'h0, capture_en}, 16'h1);
      tick();
      check("t2_cap_T5", {15'h0, capture_en}, 16'h1);
      tick();
      check("t2_cap_T6", {15'h0, capture_en}, 16'h0);
      check("t2_dp", {15'h0, done_pulse}, 16'h1);
      n_cap = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (capture_en) n_cap++;
      end
      check("t2_no_retrig", n_cap[15:0], 16'd0);

      // 3: delay 0, count 0 goes straight to DONE
      wr(3'd1, 8'h00);
      wr(3'd3, 8'h00);
      wr(3'd0, 8'h01);
      rd(3'd0, rd_v);
      check("t3_stat_armed", {8'h0, rd_v}, 16'h01);
      n_cap = 0;
      n_dp = 0;
      trig();
      for (int i = 0; i < 6; i++) begin
         if (capture_en) n_cap++;
         if (done_pulse) n_dp++;
         tick();
      end
      check("t3_cap_cnt", n_cap[15:0], 16'd0);
      check("t3_dp_cnt", n_dp[15:0], 16'd1);
      rd(3'd0, rd_v);
      check("t3_stat", {8'h0, rd_v}, 16'h04);

      // 4: abort mid-capture, then full re-run of 10 cycles
      wr(3'd3, 8'h0a);
      wr(3'd0, 8'h01);
      trig();
      tick();
      tick();
      tick();
      check("t4_cap_mid", {15'h0, capture_en}, 16'h1);
      wr(3'd0, 8'h02);
      check("t4_cap_abort", {15'h0, capture_en}, 16'h0);
      rd(3'd0, rd_v);
      check("t4_stat", {8'h0, rd_v}, 16'h00);
      n_dp = 0;
      for (int i = 0; i < 12; i++) begin
         if (done_pulse) n_dp++;
         tick();
      end
      check("t4_no_dp", n_dp[15:0], 16'd0);
      wr(3'd0, 8'h01);
      trig();
      n_cap = 0;
      n_dp = 0;
      first_cap = -1;
      for (int i = 1; i <= 14; i++) begin
         tick();
         if (capture_en) begin
            n_cap++;
            if (first_cap < 0) first_cap = i;
         end
         if (done_pulse) n_dp++;
      end
      check("t4_cap_cnt", n_cap[15:0], 16'd10);
      check("t4_cap_first", first_cap[15:0], 16'd1);
      check("t4_dp_cnt", n_dp[15:0], 16'd1);

      // 5: config writes locked outside IDLE/DONE; arm+abort
      wr(3'd0, 8'h01);
      wr(3'd1, 8'h55);
      wr(3'd3, 8'h02);
      wr(3'd4, 8'h01);
      rd(3'd1, rd_v);
      check("t5_dly_lock", {8'h0, rd_v}, 16'h00);
      rd(3'd3, rd_v);
      check("t5_cntl_lock", {8'h0, rd_v}, 16'h0a);
      rd(3'd4, rd_v);
      check("t5_cnth_lock", {8'h0, rd_v}, 16'h00);
      wr(3'd0, 8'h02);
      wr(3'd1, 8'h55);
      wr(3'd3, 8'h02);
      wr(3'd4, 8'h01);
      wr(3'd5, 8'hff);
      rd(3'd1, rd_v);
      check("t5_dly", {8'h0, rd_v}, 16'h55);
      rd(3'd3, rd_v);
      check("t5_cntl", {8'h0, rd_v}, 16'h02);
      rd(3'd4, rd_v);
      check("t5_cnth", {8'h0, rd_v}, 16'h01);
      rd(3'd5, rd_v);
      check("t5_adr5", {8'h0, rd_v}, 16'h00);
      wr(3'd0, 8'h03);
      rd(3'd0, rd_v);
      check("t5_armabort", {8'h0, rd_v}, 16'h00);
      check("t5_active", {15'h0, sq_active}, 16'h0);

      // 6: reset mid-delay clears everything
      wr(3'd0, 8'h01);
      trig();
      tick();
      tick();
      rd(3'd0, rd_v);
      check("t6_stat_busy", {8'h0, rd_v}, 16'h02);
      rst_n = 1'b0;
      #1;
      check("t6_active", {15'h0, sq_active}, 16'h0);
      check("t6_cap", {15'h0, capture_en}, 16'h0);
      check("t6_dp", {15'h0, done_pulse}, 16'h0);
      tick();
      rst_n = 1'b1;
      tick();
      rd(3'd0, rd_v);
      check("t6_stat", {8'h0, rd_v}, 16'h00);
      rd(3'd1, rd_v);
      check("t6_dly", {8'h0, rd_v}, 16'h00);
      rd(3'd3, rd_v);
      check("t6_cntl", {8'h0, rd_v}, 16'h00);
      rd(3'd4, rd_v);
      check("t6_cnth", {8'h0, rd_v}, 16'h00);

      // reset during capture drops capture_en without a clock edge
      wr(3'd3, 8'h05);
      wr(3'd0, 8'h01);
      trig();
      tick();
      tick();
      check("t7_cap_on", {15'h0, capture_en}, 16'h1);
      rst_n = 1'b0;
      #1;
      check("t7_cap_async", {15'h0, capture_en}, 16'h0);
      tick();
      rst_n = 1'b1;
      tick();
      rd(3'd0, rd_v);
      check("t7_stat", {8'h0, rd_v}, 16'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
